// File: rtl/fpu_issue_pkg.sv
// fpu_issue_pkg: shared types and constants for the fpu_issue block.
// Holds the issue FSM state encoding, the default DEPTH/TAG_W/TIMEOUT values
// and the helper that sizes the WAIT-cycle counter from TIMEOUT.
package fpu_issue_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TAG_W   = 5;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  // The wait counter only has to count 0..TIMEOUT-1; the capture is forced
  // on the cycle the counter reaches TIMEOUT-1.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// fpu_issue_fifo: request FIFO holding {tag, op} words for the issue FSM.
// Latency: a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: pushes are ignored when full and pops when empty; pointers wrap modulo DEPTH.
// Ports: clk/reset, push_i/pop_i strobes, wdata_i in, rdata_o head, full_o/empty_o/count_o status.
module fpu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the natural pointer rollover is the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpu_issue.sv
// fpu_issue: queues single-precision requests and issues them one at a time to a
// single-operand unit, capturing the result (or a timeout error) for the consumer.
// Latency: push into an idle, empty block -> out_valid 3 edges later; one result per 3 cycles.
// Backpressure: in_ready = FIFO not full; the result is held stable in HOLD until out_ready.
// Ports: in_* request side, u_* unit side, out_* result side, busy status.
module fpu_issue
  import fpu_issue_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      u_op,
  input  logic [31:0]      u_result,
  input  logic             u_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int CNT_W = wait_cnt_w(TIMEOUT);
  localparam int FW    = TAG_W + 32;
  localparam int FCW   = $clog2(DEPTH+1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      u_op_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      res_q;
  logic [TAG_W-1:0] otag_q;
  logic             err_q;

  logic             fifo_full, fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [FW-1:0]    fifo_rdata;
  logic             push, pop, cap, cap_err;

  // in_ready comes from registered FIFO state only: a pop on the same edge
  // does not open a slot for a push when full.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;

  fpu_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_tag, in_op}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    cap     = 1'b0;
    cap_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      // One cycle for the unit to see the new operand before we start waiting.
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (u_ready) begin
          cap     = 1'b1;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Last permitted WAIT cycle: take whatever the unit drives, flagged.
          cap     = 1'b1;
          cap_err = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      u_op_q  <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      otag_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // u_op only changes on a pop, so it is stable from ISSUE through HOLD.
      if (pop) {tag_q, u_op_q} <= fifo_rdata;
      if (cap) begin
        res_q  <= u_result;
        otag_q <= tag_q;
        err_q  <= cap_err;
      end
    end
  end

  assign u_op       = u_op_q;
  assign out_valid  = (state_q == S_HOLD);
  assign out_result = res_q;
  assign out_tag    = otag_q;
  assign out_err    = err_q;
  assign busy       = (state_q != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: randomized and directed stimulus against a queue-based reference
// model of fpu_issue driving a fabs unit (sign bit cleared) downstream.
module tb_fpu_issue;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      u_op;
  logic [31:0]      u_result;
  logic             u_ready;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  fpu_issue #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .u_op       (u_op),
    .u_result   (u_result),
    .u_ready    (u_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream fabs unit.
  assign u_result = {1'b0, u_op[30:0]};

  typedef struct {
    logic [31:0]      op;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             exp_q[$];
  logic             exp_err = 1'b0;
  int               n_checks = 0;
  int               n_errors = 0;
  int               cycle = 0;
  int               n_pop = 0;
  int               last_pop = -1;
  bit               tput_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, exp, cycle);
    end
  endtask

  // One clock: record handshakes as the coming edge will see them, then
  // advance and check that a stalled result did not move.
  task automatic tick();
    bit               push_f, pop_f, hold_f;
    req_t             r;
    logic [31:0]      p_res;
    logic [TAG_W-1:0] p_tag;
    logic             p_err;
    push_f = in_valid && in_ready && !reset;
    pop_f  = out_valid && out_ready && !reset;
    hold_f = out_valid && !out_ready && !reset;
    p_res  = out_result;
    p_tag  = out_tag;
    p_err  = out_err;
    if (pop_f) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 64'd1, 64'd0);
      end else begin
        r = exp_q.pop_front();
        check("result", out_result, r.op & 32'h7FFF_FFFF);
        check("tag", out_tag, r.tag);
        check("err", out_err, exp_err);
      end
      n_pop++;
      if (tput_chk && last_pop >= 0) check("throughput", cycle - last_pop, 3);
      last_pop = cycle;
    end
    if (push_f) begin
      r.op  = in_op;
      r.tag = in_tag;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cycle++;
    if (hold_f) begin
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, p_res);
      check("hold_tag", out_tag, p_tag);
      check("hold_err", out_err, p_err);
    end
  endtask

  task automatic offer(input logic [31:0] op, input logic [TAG_W-1:0] tag);
    int n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("offer_stall", in_ready, 1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int waited);
    waited = 0;
    while (!out_valid && waited < 100) begin
      tick();
      waited++;
    end
    if (!out_valid) check("wait_out_budget", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    check("drain_busy", busy, 0);
    check("drain_queue", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w;
    int          idx;
    int          pops0;
    bit          fire;
    logic [31:0] ops [6];

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_tag    = '0;
    u_ready   = 1'b1;
    out_ready = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_u_op", u_op, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    reset = 1'b0;
    tick();

    // Single request: fixed 3-edge latency.
    in_valid = 1'b1;
    in_op    = 32'hC049_0FDB;
    in_tag   = 5'd3;
    tick();
    in_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      check($sformatf("lat_edge%0d", e), out_valid, (e == 3) ? 1 : 0);
      if (e < 3) tick();
    end
    check("single_result", out_result, 32'h4049_0FDB);
    check("single_tag", out_tag, 3);
    check("single_err", out_err, 0);
    check("single_u_op", u_op, 32'hC049_0FDB);
    drain();

    // Fill with the consumer stalled: one request in flight plus DEPTH queued.
    for (int i = 0; i < 6; i++) ops[i] = $urandom;
    idx = 0;
    for (int c = 0; c < 12 && idx < 6; c++) begin
      in_valid = 1'b1;
      in_op    = ops[idx];
      in_tag   = TAG_W'(idx + 10);
      fire     = in_ready;
      tick();
      if (fire) idx++;
    end
    check("fill_accepted", idx, 5);
    check("fill_in_ready", in_ready, 0);
    check("fill_count", dut.u_fifo.count_o, DEPTH);
    pops0     = n_pop;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 6; c++) begin
      fire = in_ready;
      tick();
      if (fire) idx++;
    end
    in_valid = 1'b0;
    check("fill_last_accepted", idx, 6);
    drain();
    check("fill_all_out", n_pop - pops0, 6);

    // Backpressure for 10 cycles, then back-to-back drain.
    for (int i = 0; i < 4; i++) offer($urandom, TAG_W'(20 + i));
    wait_out(w);
    repeat (10) tick();
    pops0    = n_pop;
    tput_chk = 1'b1;
    last_pop = -1;
    drain();
    tput_chk = 1'b0;
    check("bp_all_out", n_pop - pops0, 4);

    // Timeout: unit never ready.
    u_ready = 1'b0;
    exp_err = 1'b1;
    offer(32'h8000_1234, 5'd7);
    wait_out(w);
    check("tmo_latency", w, 2 + TIMEOUT);
    check("tmo_err", out_err, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    u_ready   = 1'b1;
    exp_err   = 1'b0;
    offer(32'hBF80_0000, 5'd8);
    wait_out(w);
    check("post_tmo_latency", w, 3);
    check("post_tmo_err", out_err, 0);
    drain();

    // Reset while waiting with two entries queued.
    u_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer($urandom, TAG_W'(i));
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    tick();
    reset   = 1'b0;
    u_ready = 1'b1;
    check("rst_next_busy", busy, 0);
    check("rst_next_in_ready", in_ready, 1);
    for (int c = 0; c < 20; c++) begin
      check("rst_no_result", out_valid, 0);
      tick();
    end

    // Push and pop on the same edge at count 2, repeated across pointer wrap.
    for (int i = 0; i < 3; i++) offer($urandom, TAG_W'(i + 1));
    wait_out(w);
    check("pp_count_start", dut.u_fifo.count_o, 2);
    for (int k = 0; k < 6; k++) begin
      in_valid  = 1'b1;
      in_op     = $urandom;
      in_tag    = TAG_W'(k + 16);
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("pp_count", dut.u_fifo.count_o, 2);
      wait_out(w);
    end
    drain();

    // Random traffic with random consumer stalls.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(1, 0) == 1);
      in_op     = $urandom;
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
